// File: rtl/store_write_buffer_if.sv
// Store-buffer bus bundle: MEM-stage store/load request side plus data-memory write side.
// The master drives requests and mem_ack; the slave is the buffer itself.
interface store_write_buffer_if #(
    parameter int unsigned AW = 32
);
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic [1:0]    st_size;
    logic          st_ready;
    logic          misalign;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_conflict;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_ack;
    logic          empty;

    modport master (
        output st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, mem_ack,
        input  st_ready, misalign, ld_conflict, mem_req, mem_addr, mem_wdata, mem_be, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, mem_ack,
        output st_ready, misalign, ld_conflict, mem_req, mem_addr, mem_wdata, mem_be, empty
    );
endinterface

// File: rtl/store_write_buffer.sv
// Store write buffer: lane-aligns sb/sh/sw stores, queues them in order and drains
// them to data memory over req/ack; flags loads that hit a pending store word.
module store_write_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input logic                  clk,
    input logic                  reset,
    store_write_buffer_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WW = AW - 2;

    typedef struct packed {
        logic [WW-1:0] waddr;
        logic [3:0]    be;
        logic [31:0]   data;
    } entry_t;

    typedef enum logic {IDLE, REQ} state_t;

    state_t           state_q, state_d;
    entry_t           fifo_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q, rd_next;
    logic [CW-1:0]    count_q;
    entry_t           head_q, head_d;
    logic             mem_req_q, req_d;
    logic             misalign_q;
    entry_t           st_entry;
    logic             legal, push, pop, full;
    logic [DEPTH-1:0] hit;

    // Lane alignment and legality of the incoming store.
    always_comb begin
        st_entry.waddr = bus.st_addr[AW-1:2];
        st_entry.be    = 4'b0000;
        st_entry.data  = bus.st_data;
        legal          = 1'b0;
        unique case (bus.st_size)
            2'b00: begin
                legal         = 1'b1;
                st_entry.be   = 4'b0001 << bus.st_addr[1:0];
                st_entry.data = {4{bus.st_data[7:0]}};
            end
            2'b01: begin
                legal         = ~bus.st_addr[0];
                st_entry.be   = bus.st_addr[1] ? 4'b1100 : 4'b0011;
                st_entry.data = {2{bus.st_data[15:0]}};
            end
            2'b10: begin
                legal         = (bus.st_addr[1:0] == 2'b00);
                st_entry.be   = 4'b1111;
                st_entry.data = bus.st_data;
            end
            default: legal = 1'b0;
        endcase
    end

    assign full    = (count_q == CW'(DEPTH));
    assign push    = bus.st_valid & ~full & legal;
    assign rd_next = rd_ptr_q + PW'(1);

    // Drain FSM: the head stays counted and comparable until its ack edge.
    always_comb begin
        state_d = state_q;
        req_d   = mem_req_q;
        head_d  = head_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    head_d  = fifo_q[rd_ptr_q];
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    pop = 1'b1;
                    if (count_q > CW'(1)) begin
                        head_d = fifo_q[rd_next];
                    end else if (push) begin
                        // Sole entry leaving while a new one arrives: bypass the array.
                        head_d = st_entry;
                    end else begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            head_q     <= '0;
            misalign_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= req_d;
            head_q     <= head_d;
            misalign_q <= bus.st_valid & ~legal;
            if (push) begin
                wr_ptr_q          <= wr_ptr_q + PW'(1);
                valid_q[wr_ptr_q] <= 1'b1;
            end
            if (pop) begin
                rd_ptr_q          <= rd_next;
                valid_q[rd_ptr_q] <= 1'b0;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= st_entry;
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = valid_q[i] & (fifo_q[i].waddr == bus.ld_addr[AW-1:2]);
        end
    end

    assign bus.ld_conflict = bus.ld_valid & (|hit);
    assign bus.st_ready    = ~full;
    assign bus.empty       = (count_q == '0);
    assign bus.misalign    = misalign_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = {head_q.waddr, 2'b00};
    assign bus.mem_wdata   = head_q.data;
    assign bus.mem_be      = head_q.be;
endmodule

// File: tb/tb_store_write_buffer.sv
// Directed self-checking bench for store_write_buffer (DEPTH=4, AW=32).
module tb_store_write_buffer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    store_write_buffer_if #(.AW(32)) bus ();

    store_write_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_st(input logic v, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] sz);
        bus.st_valid = v;
        bus.st_addr  = a;
        bus.st_data  = d;
        bus.st_size  = sz;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_st(1'b0, 32'h0, 32'h0, 2'b00);
        bus.ld_valid = 1'b0;
        bus.ld_addr  = 32'h0;
        bus.mem_ack  = 1'b0;
        step();
        step();
        reset = 1'b0;
        checks++;
        if ({bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== {1'b0, 32'h0, 32'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset_mem got req=%b addr=%h wd=%h be=%b want 0", bus.mem_req, bus.mem_addr,
                     bus.mem_wdata, bus.mem_be);
        end
        checks++;
        if ({bus.st_ready, bus.empty, bus.misalign} !== 3'b110) begin
            errors++;
            $display("FAIL reset_flags got rdy/empty/mis=%b%b%b want 110", bus.st_ready, bus.empty,
                     bus.misalign);
        end
    endtask

    task automatic test_word();
        bus.mem_ack = 1'b1;
        drive_st(1'b1, 32'h100, 32'hDEADBEEF, 2'b10);
        step();
        drive_st(1'b0, 32'h0, 32'h0, 2'b00);
        checks++;
        if ({bus.mem_req, bus.empty} !== 2'b00) begin
            errors++;
            $display("FAIL word_edge1 got req=%b empty=%b want req=0 empty=0", bus.mem_req, bus.empty);
        end
        step();
        checks++;
        if ({bus.mem_req, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== {1'b1, 32'h100, 4'hF, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL word_req got req=%b addr=%h be=%b wd=%h want 1 00000100 1111 deadbeef",
                     bus.mem_req, bus.mem_addr, bus.mem_be, bus.mem_wdata);
        end
        step();
        checks++;
        if ({bus.mem_req, bus.empty} !== 2'b01) begin
            errors++;
            $display("FAIL word_done got req=%b empty=%b want req=0 empty=1", bus.mem_req, bus.empty);
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_order();
        drive_st(1'b1, 32'h103, 32'h0000005A, 2'b00);
        step();
        drive_st(1'b1, 32'h106, 32'h00001234, 2'b01);
        step();
        drive_st(1'b0, 32'h0, 32'h0, 2'b00);
        checks++;
        if ({bus.mem_req, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== {1'b1, 32'h100, 4'b1000, 32'h5A5A5A5A}) begin
            errors++;
            $display("FAIL order_sb got req=%b addr=%h be=%b wd=%h want 1 00000100 1000 5a5a5a5a",
                     bus.mem_req, bus.mem_addr, bus.mem_be, bus.mem_wdata);
        end
        bus.mem_ack = 1'b1;
        step();
        checks++;
        if ({bus.mem_req, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== {1'b1, 32'h104, 4'b1100, 32'h12341234}) begin
            errors++;
            $display("FAIL order_sh got req=%b addr=%h be=%b wd=%h want 1 00000104 1100 12341234",
                     bus.mem_req, bus.mem_addr, bus.mem_be, bus.mem_wdata);
        end
        step();
        bus.mem_ack = 1'b0;
        checks++;
        if ({bus.mem_req, bus.empty} !== 2'b01) begin
            errors++;
            $display("FAIL order_done got req=%b empty=%b want 0 1", bus.mem_req, bus.empty);
        end
    endtask

    task automatic test_full();
        logic [31:0] exp_addr;
        for (int i = 0; i < 4; i++) begin
            drive_st(1'b1, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i), 2'b10);
            step();
        end
        checks++;
        if (bus.st_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready got st_ready=%b want 0", bus.st_ready);
        end
        drive_st(1'b1, 32'h310, 32'hA4, 2'b10);
        step();
        checks++;
        if ({bus.st_ready, bus.mem_req, bus.mem_addr} !== {1'b0, 1'b1, 32'h300}) begin
            errors++;
            $display("FAIL full_hold got rdy=%b req=%b addr=%h want 0 1 00000300", bus.st_ready,
                     bus.mem_req, bus.mem_addr);
        end
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        checks++;
        if ({bus.st_ready, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'h304, 32'hA1}) begin
            errors++;
            $display("FAIL full_pop got rdy=%b addr=%h wd=%h want 1 00000304 000000a1", bus.st_ready,
                     bus.mem_addr, bus.mem_wdata);
        end
        step();
        drive_st(1'b0, 32'h0, 32'h0, 2'b00);
        checks++;
        if (bus.st_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_take5 got st_ready=%b want 0", bus.st_ready);
        end
        bus.mem_ack = 1'b1;
        for (int i = 2; i < 5; i++) begin
            step();
            exp_addr = 32'h300 + 32'(4 * i);
            checks++;
            if ({bus.mem_req, bus.mem_addr, bus.mem_wdata} !== {1'b1, exp_addr, 32'hA0 + 32'(i)}) begin
                errors++;
                $display("FAIL full_drain%0d got req=%b addr=%h wd=%h want 1 %h %h", i, bus.mem_req,
                         bus.mem_addr, bus.mem_wdata, exp_addr, 32'hA0 + 32'(i));
            end
        end
        step();
        bus.mem_ack = 1'b0;
        checks++;
        if ({bus.mem_req, bus.empty} !== 2'b01) begin
            errors++;
            $display("FAIL full_done got req=%b empty=%b want 0 1", bus.mem_req, bus.empty);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        addrs[0] = 32'h101; sizes[0] = 2'b01;
        addrs[1] = 32'h102; sizes[1] = 2'b10;
        addrs[2] = 32'h100; sizes[2] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            drive_st(1'b1, addrs[i], 32'hFFFF_FFFF, sizes[i]);
            step();
            checks++;
            if ({bus.misalign, bus.empty, bus.st_ready} !== 3'b111) begin
                errors++;
                $display("FAIL misalign%0d got mis=%b empty=%b rdy=%b want 1 1 1", i, bus.misalign,
                         bus.empty, bus.st_ready);
            end
        end
        drive_st(1'b0, 32'h0, 32'h0, 2'b00);
        step();
        checks++;
        if ({bus.misalign, bus.empty, bus.mem_req} !== 3'b010) begin
            errors++;
            $display("FAIL misalign_end got mis=%b empty=%b req=%b want 0 1 0", bus.misalign,
                     bus.empty, bus.mem_req);
        end
        step();
        checks++;
        if ({bus.mem_req, bus.empty} !== 2'b01) begin
            errors++;
            $display("FAIL misalign_noreq got req=%b empty=%b want 0 1", bus.mem_req, bus.empty);
        end
    endtask

    task automatic test_conflict();
        drive_st(1'b1, 32'h200, 32'h55, 2'b10);
        step();
        drive_st(1'b0, 32'h0, 32'h0, 2'b00);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h203;
        #1;
        checks++;
        if (bus.ld_conflict !== 1'b1) begin
            errors++;
            $display("FAIL conflict_hit got %b want 1", bus.ld_conflict);
        end
        bus.ld_addr = 32'h204;
        #1;
        checks++;
        if (bus.ld_conflict !== 1'b0) begin
            errors++;
            $display("FAIL conflict_miss got %b want 0", bus.ld_conflict);
        end
        bus.ld_addr = 32'h203;
        step();
        checks++;
        if ({bus.mem_req, bus.ld_conflict} !== 2'b11) begin
            errors++;
            $display("FAIL conflict_inflight got req=%b conf=%b want 1 1", bus.mem_req, bus.ld_conflict);
        end
        bus.ld_valid = 1'b0;
        #1;
        checks++;
        if (bus.ld_conflict !== 1'b0) begin
            errors++;
            $display("FAIL conflict_noload got %b want 0", bus.ld_conflict);
        end
        bus.ld_valid = 1'b1;
        bus.mem_ack  = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        checks++;
        if ({bus.ld_conflict, bus.empty} !== 2'b01) begin
            errors++;
            $display("FAIL conflict_acked got conf=%b empty=%b want 0 1", bus.ld_conflict, bus.empty);
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive_st(1'b1, 32'h600, 32'hAAAA_AAAA, 2'b10);
        step();
        drive_st(1'b0, 32'h0, 32'h0, 2'b00);
        step();
        drive_st(1'b1, 32'h604, 32'h1122_3344, 2'b10);
        bus.mem_ack = 1'b1;
        step();
        drive_st(1'b0, 32'h0, 32'h0, 2'b00);
        checks++;
        if ({bus.mem_req, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== {1'b1, 32'h604, 4'hF, 32'h11223344}) begin
            errors++;
            $display("FAIL b2b_bypass got req=%b addr=%h be=%b wd=%h want 1 00000604 1111 11223344",
                     bus.mem_req, bus.mem_addr, bus.mem_be, bus.mem_wdata);
        end
        step();
        bus.mem_ack = 1'b0;
        checks++;
        if ({bus.mem_req, bus.empty} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_done got req=%b empty=%b want 0 1", bus.mem_req, bus.empty);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive_st(1'b1, 32'h400 + 32'(4 * i), 32'h70 + 32'(i), 2'b10);
            step();
        end
        drive_st(1'b0, 32'h0, 32'h0, 2'b00);
        checks++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h400}) begin
            errors++;
            $display("FAIL rstmid_req got req=%b addr=%h want 1 00000400", bus.mem_req, bus.mem_addr);
        end
        reset = 1'b1;
        step();
        reset       = 1'b0;
        bus.mem_ack = 1'b1;
        checks++;
        if ({bus.mem_req, bus.empty, bus.st_ready} !== 3'b011) begin
            errors++;
            $display("FAIL rstmid_clear got req=%b empty=%b rdy=%b want 0 1 1", bus.mem_req,
                     bus.empty, bus.st_ready);
        end
        step();
        step();
        bus.mem_ack = 1'b0;
        checks++;
        if ({bus.mem_req, bus.empty, bus.st_ready} !== 3'b011) begin
            errors++;
            $display("FAIL rstmid_stale got req=%b empty=%b rdy=%b want 0 1 1", bus.mem_req,
                     bus.empty, bus.st_ready);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_word();
        test_order();
        test_full();
        test_misalign();
        test_conflict();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
